// File: rtl/decoder_130b128b.sv
// 128b/130b receive decoder: sync-header check, block-lock FSM with bit-slip requests, payload forwarding.
// Optional saturating bad-header counter is built when DEC130_ERRCNT_EN is defined.
module decoder_130b128b #(
  parameter int LOCK_CNT   = 64,
  parameter int WIN_LEN    = 1024,
  parameter int ERR_THRESH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [129:0] block_in,
  input  logic         valid_in,
`ifdef DEC130_ERRCNT_EN
  input  logic         clr_err_cnt,
  output logic [15:0]  err_count,
`endif
  output logic [127:0] data_out,
  output logic         block_type,
  output logic         valid_out,
  output logic         sync_err,
  output logic         slip_req,
  output logic         locked
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int BW = $clog2(ERR_THRESH + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_LEN - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(ERR_THRESH - 1);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_good_cnt;
  logic [WW-1:0] r_win_cnt;
  logic [BW-1:0] r_bad_cnt;

  logic [1:0] w_hdr;
  logic       w_good;
  logic       w_bad;

  assign w_hdr  = block_in[129:128];
  assign w_good = (w_hdr == 2'b01) || (w_hdr == 2'b10);
  assign w_bad  = !w_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_bad_cnt  <= '0;
      data_out   <= '0;
      block_type <= 1'b0;
      valid_out  <= 1'b0;
      sync_err   <= 1'b0;
      slip_req   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: the pulse defaults below are overridden by any later
      // assignment in this block, and every branch reads the pre-edge counter values.
      valid_out <= 1'b0;
      sync_err  <= 1'b0;
      slip_req  <= 1'b0;
      if (valid_in) begin
        unique case (r_state)
          ST_HUNT: begin
            if (w_good) begin
              // The block completing lock is consumed, not forwarded.
              if (r_good_cnt == GOOD_LAST) begin
                r_state    <= ST_LOCKED;
                locked     <= 1'b1;
                r_good_cnt <= '0;
                r_win_cnt  <= '0;
                r_bad_cnt  <= '0;
              end else begin
                r_good_cnt <= r_good_cnt + 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
              sync_err   <= 1'b1;
              slip_req   <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (w_good) begin
              valid_out  <= 1'b1;
              data_out   <= block_in[127:0];
              block_type <= w_hdr[1];
            end else begin
              sync_err <= 1'b1;
            end
            // Loss of lock is checked before the window wrap so it wins on the last block.
            if (w_bad && (r_bad_cnt == BAD_LAST)) begin
              r_state    <= ST_HUNT;
              locked     <= 1'b0;
              slip_req   <= 1'b1;
              r_good_cnt <= '0;
              r_win_cnt  <= '0;
              r_bad_cnt  <= '0;
            end else if (r_win_cnt == WIN_LAST) begin
              r_win_cnt <= '0;
              r_bad_cnt <= '0;
            end else begin
              r_win_cnt <= r_win_cnt + 1'b1;
              if (w_bad) begin
                r_bad_cnt <= r_bad_cnt + 1'b1;
              end
            end
          end
          default: r_state <= ST_HUNT;
        endcase
      end
    end
  end

`ifdef DEC130_ERRCNT_EN
  // Clear has priority over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err_cnt) begin
      err_count <= '0;
    end else if (valid_in && w_bad && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_130b128b.sv
// Self-checking bench for decoder_130b128b: directed vector table, hand sequences, and
// randomized blocks compared against a block-level reference model.
module tb_decoder_130b128b;

  localparam int LOCK_CNT   = 4;
  localparam int WIN_LEN    = 8;
  localparam int ERR_THRESH = 3;

  logic         clk;
  logic         rst_n;
  logic [129:0] block_in;
  logic         valid_in;
  logic         clr_err_cnt;
  logic [127:0] data_out;
  logic         block_type;
  logic         valid_out;
  logic         sync_err;
  logic         slip_req;
  logic         locked;
`ifdef DEC130_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  decoder_130b128b #(
    .LOCK_CNT  (LOCK_CNT),
    .WIN_LEN   (WIN_LEN),
    .ERR_THRESH(ERR_THRESH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .block_in   (block_in),
    .valid_in   (valid_in),
`ifdef DEC130_ERRCNT_EN
    .clr_err_cnt(clr_err_cnt),
    .err_count  (err_count),
`endif
    .data_out   (data_out),
    .block_type (block_type),
    .valid_out  (valid_out),
    .sync_err   (sync_err),
    .slip_req   (slip_req),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks lock as a run length of good headers and, while locked,
  // the count of bad headers in the window indexed by (blocks since lock) / WIN_LEN.
  bit           m_lk;
  int           m_run, m_since, m_cur_win, m_bad_win;
  logic         e_vo, e_se, e_sr, e_bt;
  logic [127:0] e_do;
  logic [15:0]  e_err;

  task automatic model_reset();
    m_lk = 0; m_run = 0; m_since = 0; m_cur_win = 0; m_bad_win = 0;
    e_vo = 0; e_se = 0; e_sr = 0; e_bt = 0; e_do = '0; e_err = '0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] h, input logic [127:0] p, input bit clr);
    bit good;
    good = (h == 2'b01) || (h == 2'b10);
    e_vo = 0; e_se = 0; e_sr = 0;
    if (v) begin
      if (!good && e_err != 16'hFFFF) e_err = e_err + 16'd1;
      if (!m_lk) begin
        if (good) begin
          m_run++;
          if (m_run == LOCK_CNT) begin
            m_lk = 1; m_run = 0; m_since = 0; m_cur_win = 0; m_bad_win = 0;
          end
        end else begin
          m_run = 0; e_se = 1; e_sr = 1;
        end
      end else begin
        if (m_since / WIN_LEN != m_cur_win) begin
          m_cur_win = m_since / WIN_LEN;
          m_bad_win = 0;
        end
        m_since++;
        if (good) begin
          e_vo = 1; e_do = p; e_bt = (h == 2'b10);
        end else begin
          e_se = 1;
          m_bad_win++;
          if (m_bad_win == ERR_THRESH) begin
            e_sr = 1; m_lk = 0; m_run = 0;
          end
        end
      end
    end
    if (clr) e_err = '0;
  endtask

  task automatic step(input bit v, input logic [1:0] h, input logic [127:0] p, input bit clr);
    valid_in    = v;
    block_in    = {h, p};
    clr_err_cnt = clr;
    model_step(v, h, p, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 0; valid_in = 0; block_in = '0; clr_err_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_slip_req", slip_req, 0);
    check("rst_locked", locked, 0);
    check("rst_data_out", data_out, 0);
    rst_n = 1;
  endtask

  typedef struct {
    bit           rst;
    bit           v;
    logic [1:0]   hdr;
    logic [127:0] pay;
    bit           vo, se, sr, lk, bt;
    logic [127:0] dout;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, bit v, logic [1:0] h, logic [127:0] p,
                              bit vo, bit se, bit sr, bit lk, bit bt, logic [127:0] d);
    vec_t e;
    e = '{rst, v, h, p, vo, se, sr, lk, bt, d};
    tbl.push_back(e);
  endfunction

  initial begin
    rst_n = 0; valid_in = 0; block_in = '0; clr_err_cnt = 0;
    model_reset();

    // Lock after 4 goods (none forwarded), then 2 bad per window over two windows.
    add(1, 1, 2'b01, 128'h1,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h2,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h3,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h4,    0, 0, 0, 1, 0, 128'h0);
    add(0, 1, 2'b10, 128'hABCD, 1, 0, 0, 1, 1, 128'hABCD);
    add(0, 1, 2'b11, 128'h0,    0, 1, 0, 1, 1, 128'hABCD);
    add(0, 1, 2'b00, 128'h0,    0, 1, 0, 1, 1, 128'hABCD);
    for (int i = 1; i <= 5; i++)
      add(0, 1, 2'b01, 128'h20 + 128'(i), 1, 0, 0, 1, 0, 128'h20 + 128'(i));
    add(0, 1, 2'b11, 128'h0,    0, 1, 0, 1, 0, 128'h25);
    add(0, 1, 2'b11, 128'h0,    0, 1, 0, 1, 0, 128'h25);
    add(0, 1, 2'b10, 128'h55,   1, 0, 0, 1, 1, 128'h55);
    // Bad at window positions 1, 4, 7 -> loss of lock on the third.
    add(1, 1, 2'b01, 128'h1,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h2,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h3,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h4,    0, 0, 0, 1, 0, 128'h0);
    add(0, 1, 2'b11, 128'h0,    0, 1, 0, 1, 0, 128'h0);
    add(0, 1, 2'b01, 128'hB2,   1, 0, 0, 1, 0, 128'hB2);
    add(0, 1, 2'b10, 128'hB3,   1, 0, 0, 1, 1, 128'hB3);
    add(0, 1, 2'b00, 128'h0,    0, 1, 0, 1, 1, 128'hB3);
    add(0, 1, 2'b01, 128'hB5,   1, 0, 0, 1, 0, 128'hB5);
    add(0, 1, 2'b10, 128'hB6,   1, 0, 0, 1, 1, 128'hB6);
    add(0, 1, 2'b11, 128'h0,    0, 1, 1, 0, 1, 128'hB6);
    add(0, 1, 2'b01, 128'hB8,   0, 0, 0, 0, 1, 128'hB6);
    // HUNT: 3 good, one bad, then 4 good needed.
    add(1, 1, 2'b01, 128'h1,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h2,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h3,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b11, 128'h0,    0, 1, 1, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h5,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h6,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h7,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'hC8,   0, 0, 0, 1, 0, 128'h0);
    add(0, 1, 2'b01, 128'hC9,   1, 0, 0, 1, 0, 128'hC9);
    // valid_in toggling with bad headers on idle cycles.
    add(1, 1, 2'b01, 128'h1,    0, 0, 0, 0, 0, 128'h0);
    add(0, 0, 2'b11, 128'h0,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h2,    0, 0, 0, 0, 0, 128'h0);
    add(0, 0, 2'b11, 128'h0,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h3,    0, 0, 0, 0, 0, 128'h0);
    add(0, 0, 2'b00, 128'h0,    0, 0, 0, 0, 0, 128'h0);
    add(0, 1, 2'b01, 128'h4,    0, 0, 0, 1, 0, 128'h0);
    add(0, 0, 2'b10, 128'hFF,   0, 0, 0, 1, 0, 128'h0);
    add(0, 0, 2'b11, 128'h0,    0, 0, 0, 1, 0, 128'h0);
    add(0, 1, 2'b10, 128'hD0,   1, 0, 0, 1, 1, 128'hD0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) reset_dut();
      step(tbl[i].v, tbl[i].hdr, tbl[i].pay, 1'b0);
      check($sformatf("vec%0d_valid_out", i), valid_out, tbl[i].vo);
      check($sformatf("vec%0d_sync_err", i), sync_err, tbl[i].se);
      check($sformatf("vec%0d_slip_req", i), slip_req, tbl[i].sr);
      check($sformatf("vec%0d_locked", i), locked, tbl[i].lk);
      check($sformatf("vec%0d_block_type", i), block_type, tbl[i].bt);
      check($sformatf("vec%0d_data_out", i), data_out, tbl[i].dout);
    end

    // Asynchronous reset while locked with valid_out high.
    rst_n = 0;
    model_reset();
    #1;
    check("midrst_locked", locked, 0);
    check("midrst_valid_out", valid_out, 0);
    check("midrst_slip_req", slip_req, 0);
    check("midrst_data_out", data_out, 0);
    #2;
    rst_n = 1;
    for (int i = 0; i < LOCK_CNT - 1; i++) begin
      step(1, 2'b01, 128'(i), 0);
      check("postrst_hunt_locked", locked, 0);
      check("postrst_hunt_valid_out", valid_out, 0);
    end
    step(1, 2'b01, 128'h77, 0);
    check("postrst_lock", locked, 1);

`ifdef DEC130_ERRCNT_EN
    reset_dut();
    check("errcnt_reset", err_count, 0);
    for (int i = 0; i < 3; i++) step(1, 2'b11, 128'h0, 0);
    check("errcnt_three", err_count, 3);
    step(1, 2'b00, 128'h0, 1);
    check("errcnt_clr_priority", err_count, 0);
`endif

    // Randomized blocks against the reference model.
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] h;
      r = int'($urandom_range(0, 15));
      h = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r[0] ? 2'b10 : 2'b01);
      step(($urandom_range(0, 4) != 0), h, {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 15) == 0));
      check("rnd_valid_out", valid_out, e_vo);
      check("rnd_sync_err", sync_err, e_se);
      check("rnd_slip_req", slip_req, e_sr);
      check("rnd_locked", locked, m_lk);
      check("rnd_block_type", block_type, e_bt);
      check("rnd_data_out", data_out, e_do);
`ifdef DEC130_ERRCNT_EN
      check("rnd_err_count", err_count, e_err);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_130b128b.md
Name: decoder_130b128b

Overview:
Receive-side counterpart of the 128b/130b transmit framer. Takes 130-bit framed blocks from the upstream deserializer/aligner and checks the 2-bit sync header. Runs a block-lock state machine that requests bit-slips from the aligner until headers are stable. Once locked, strips the header and forwards 128-bit payloads with a data/control flag to the link layer.

Parameters:
LOCK_CNT, 64, consecutive valid headers required to declare lock (>=1)
WIN_LEN, 1024, blocks per error-monitoring window while locked (>=2)
ERR_THRESH, 16, invalid headers within one window that force loss of lock (1..WIN_LEN)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
block_in  input  130  framed block; [129:128] sync header, [127:0] payload
valid_in  input  1  block_in valid this cycle
data_out  output  128  decoded payload
block_type  output  1  0 = data block (header 2'b01), 1 = control block (header 2'b10)
valid_out  output  1  data_out/block_type valid, 1-cycle pulse per block
sync_err  output  1  1-cycle pulse: invalid header (2'b00 or 2'b11) received
slip_req  output  1  1-cycle pulse: request aligner to shift block boundary by one bit
locked  output  1  block lock status

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock clk. All outputs 0 in reset; FSM = HUNT; all counters 0.
- All outputs registered; latency 1 cycle from a valid_in sample to valid_out/sync_err/slip_req.
- Header decode: 2'b01 = good data; 2'b10 = good control; 2'b00 and 2'b11 = bad.
- No backpressure: a block is accepted on every cycle with valid_in=1. Cycles with valid_in=0 change no state, and all pulse outputs are 0.
- data_out and block_type update only when valid_out is asserted; otherwise they hold.
- FSM HUNT (locked=0):
  - Good header: good_cnt++. If good_cnt reaches LOCK_CNT, go to LOCKED, clear the window and bad counters, set locked=1 the next cycle.
  - Bad header: good_cnt=0, pulse sync_err and slip_req.
  - No blocks are forwarded in HUNT. This includes the block that completes lock.
- FSM LOCKED (locked=1):
  - Every valid block increments win_cnt.
  - Good header: valid_out=1; data_out=block_in[127:0]; block_type=1 for header 2'b10, 0 for 2'b01.
  - Bad header: not forwarded; pulse sync_err; bad_cnt++.
  - If bad_cnt reaches ERR_THRESH, go to HUNT the same cycle: pulse slip_req, locked=0 next cycle, clear good_cnt, bad_cnt and win_cnt.
  - When win_cnt reaches WIN_LEN without loss of lock, clear win_cnt and bad_cnt. The block completing the window is counted in the old window.
  - If the threshold is reached on the last block of a window, loss of lock wins.
- Counter widths are $clog2(param+1). Counters never wrap: each is cleared at its terminal value.
- At most one slip_req per bad block. Back-to-back bad blocks in HUNT give back-to-back slip_req pulses.
- Reset asserted mid-stream: immediate return to reset values. The first block after release starts in HUNT with good_cnt=0.

Optional Feature:
Macro DEC130_ERRCNT_EN.
- Defined: adds input clr_err_cnt (1) and output err_count (16).
  - err_count increments once per bad header in any state and saturates at 16'hFFFF.
  - clr_err_cnt=1 clears it to 0 next cycle and takes priority over a simultaneous increment.
  - err_count resets to 0.
- Not defined: neither port exists and the logic is absent. All other behaviour is identical.

Test Plan:
- LOCK_CNT=4: four valid blocks with header 01, payload 128'h1..4 -> no valid_out for any of them; locked=1 one cycle after the 4th; next block 10/128'hABCD -> valid_out=1, block_type=1, data_out=128'hABCD.
- HUNT: 3 good blocks, then header 11, then 4 good -> sync_err and slip_req pulse once at the bad block; good_cnt restarts; locked rises only after the last 4 good.
- LOCKED, WIN_LEN=8, ERR_THRESH=3: bad headers at window positions 1, 4, 7 -> three sync_err pulses, slip_req at the 3rd, locked=0 the next cycle; the good blocks at positions 2, 3, 5, 6 are forwarded.
- LOCKED, WIN_LEN=8, ERR_THRESH=3: 2 bad in window A, 2 bad in window B -> lock retained, no slip_req.
- valid_in toggling 1/0 with a bad header held on cycles where valid_in=0 -> no sync_err and no state change on the invalid cycles.
- rst_n asserted while LOCKED mid-stream -> locked, valid_out, slip_req immediately 0. With DEC130_ERRCNT_EN: after 3 bad headers err_count=3; clr_err_cnt together with a bad header -> err_count=0.
